// File: rtl/fifo_stream_reader.sv
// Purpose: drains a synchronous FIFO (1-cycle read latency) onto a valid/ready stream via a 2-entry buffer.
// Latency: first word valid 2 cycles after the read request; 1 word/clock sustained when the sink never stalls.
// Backpressure: reads stop once buffered + in-flight words reach 2; the skid entry lets the sink restart with no bubble.
module fifo_stream_reader #(
    parameter int WIDTH       = 8,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic                   fifo_empty,
    input  logic [WIDTH-1:0]       fifo_data,
    output logic                   fifo_r_en,
    output logic                   m_valid,
    output logic [WIDTH-1:0]       m_data,
    input  logic                   m_ready,
    output logic [COUNT_WIDTH-1:0] word_count,
    output logic                   idle
);

    // A FIFO read was accepted at the last edge; its data is on fifo_data this cycle
    logic             inflight;
    // Number of valid buffer entries (0..2); head is always the older one
    logic [1:0]       occ;
    logic [WIDTH-1:0] head_q;
    logic [WIDTH-1:0] skid_q;
    logic             pop;
    // Words committed to the buffer after this edge if no new read is issued
    logic [2:0]       level;

    assign pop       = m_valid & m_ready;
    assign level     = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
    // Only issue a read if there is guaranteed room for its data next cycle
    assign fifo_r_en = rst_n & en & ~fifo_empty & (level < 3'd2);
    assign m_valid   = (occ != 2'd0);
    assign m_data    = head_q;
    assign idle      = (occ == 2'd0) & ~inflight;

    // Track the one-cycle FIFO read latency
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight <= 1'b0;
        end else begin
            inflight <= fifo_r_en;
        end
    end

    // Buffer update: capture the in-flight word and/or retire the head, preserving order
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ    <= 2'd0;
            head_q <= '0;
            skid_q <= '0;
        end else if (inflight) begin
            if (occ == 2'd0 || (occ == 2'd1 && pop)) begin
                // Head empty, or head leaving with nothing in skid: data goes straight to head
                head_q <= fifo_data;
                occ    <= 2'd1;
            end else if (occ == 2'd1) begin
                // Head stalled: park the new word behind it
                skid_q <= fifo_data;
                occ    <= 2'd2;
            end else begin
                // Full with a capture: read gating guarantees the head is popping here
                head_q <= skid_q;
                skid_q <= fifo_data;
                occ    <= 2'd2;
            end
        end else if (pop) begin
            if (occ == 2'd2) begin
                head_q <= skid_q;
                occ    <= 2'd1;
            end else begin
                occ    <= 2'd0;
            end
        end
    end

    // Count completed output handshakes, wrapping naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_count <= '0;
        end else if (pop) begin
            word_count <= word_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Purpose: randomized and directed check of fifo_stream_reader against an in-order stream model.
// Latency: model predicts valid/ready/read-enable per cycle from read and pop counts.
// Backpressure: sink readiness is randomized; outstanding words must never exceed 2.
module tb_fifo_stream_reader;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       m_ready = 1'b0;
    logic       fifo_empty = 1'b1;
    logic [7:0] fifo_data = 8'h00;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;

    logic        fifo_r_en, m_valid, idle;
    logic [7:0]  m_data;
    logic [15:0] word_count;
    logic        r_en4, valid4, idle4;
    logic [7:0]  data4;
    logic [3:0]  wc4;

    int n_vec = 0;
    int n_err = 0;

    // Bench-side FIFO storage and the expected output stream
    logic [7:0] q[$];
    logic [7:0] exp_q[$];
    int n_reads = 0;
    int n_pops  = 0;
    int last_rd = 0;
    bit prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;

    fifo_stream_reader u_dut (
        .clk(clk), .rst_n(rst_n), .en(en), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
        .fifo_r_en(fifo_r_en), .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
        .word_count(word_count), .idle(idle)
    );

    fifo_stream_reader #(.WIDTH(8), .COUNT_WIDTH(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .en(en), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
        .fifo_r_en(r_en4), .m_valid(valid4), .m_data(data4), .m_ready(m_ready),
        .word_count(wc4), .idle(idle4)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Synchronous FIFO model: registered empty flag, data valid the cycle after an accepted read
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            exp_q.delete();
            fifo_empty <= 1'b1;
            fifo_data  <= 8'h00;
            n_reads = 0;
            last_rd = 0;
        end else begin
            last_rd = 0;
            if (fifo_r_en && !fifo_empty && q.size() > 0) begin
                fifo_data <= q.pop_front();
                n_reads++;
                last_rd = 1;
            end
            if (wr_en) begin
                q.push_back(wr_data);
                exp_q.push_back(wr_data);
            end
            fifo_empty <= (q.size() == 0);
        end
    end

    // Per-cycle scoreboard, sampled mid-cycle
    always @(negedge clk) begin
        int outst;
        int pop_now;
        bit exp_vld;
        bit exp_ren;
        if (!rst_n) begin
            chk("rst_valid", m_valid, 0);
            chk("rst_data", m_data, 0);
            chk("rst_wc", word_count, 0);
            chk("rst_idle", idle, 1);
            chk("rst_ren", fifo_r_en, 0);
            n_pops = 0;
            prev_stall = 1'b0;
        end else begin
            outst   = n_reads - n_pops;
            exp_vld = (outst - last_rd) > 0;
            pop_now = (m_valid && m_ready) ? 1 : 0;
            exp_ren = en && !fifo_empty && (outst - pop_now < 2);
            chk("outstanding_le2", (outst <= 2), 1);
            chk("valid", m_valid, exp_vld);
            chk("valid4", valid4, exp_vld);
            chk("idle", idle, (outst == 0));
            chk("idle4", idle4, (outst == 0));
            chk("wc", word_count, n_pops % 65536);
            chk("wc4", wc4, n_pops % 16);
            chk("r_en", fifo_r_en, exp_ren);
            chk("r_en4", r_en4, exp_ren);
            if (prev_stall) begin
                chk("hold_valid", m_valid, 1);
                chk("hold_data", m_data, prev_data);
            end
            if (m_valid) begin
                if (exp_q.size() == 0) begin
                    chk("extra_word", m_valid, 0);
                end else begin
                    chk("data", m_data, exp_q[0]);
                    chk("data4", data4, exp_q[0]);
                end
            end
            if (pop_now == 1) begin
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                n_pops++;
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic preload(input int n, input int base);
        for (int i = 0; i < n; i++) begin
            wr_en   = 1'b1;
            wr_data = 8'(base + i);
            tick();
        end
        wr_en = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        bit done;
        done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clk);
            if (idle && fifo_empty && exp_q.size() == 0) done = 1'b1;
        end
        chk("drain_timeout", exp_q.size(), 0);
        tick();
    endtask

    initial begin
        int r0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        // Single word: one read, one valid cycle two cycles later
        en = 1'b1;
        m_ready = 1'b1;
        wr_en = 1'b1;
        wr_data = 8'hA5;
        tick();
        wr_en = 1'b0;
        @(negedge clk);
        chk("single_ren", fifo_r_en, 1);
        tick();
        @(negedge clk);
        chk("single_v0", m_valid, 0);
        tick();
        @(negedge clk);
        chk("single_v1", m_valid, 1);
        chk("single_data", m_data, 8'hA5);
        tick();
        @(negedge clk);
        chk("single_v2", m_valid, 0);
        chk("single_wc", word_count, 1);
        chk("single_idle", idle, 1);
        tick();

        // Burst: 8 consecutive valid cycles
        do_reset();
        en = 1'b0;
        preload(8, 1);
        en = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 6 && !m_valid; i++) @(negedge clk);
        chk("burst_start", m_valid, 1);
        for (int i = 0; i < 8; i++) begin
            chk("burst_vld", m_valid, 1);
            @(negedge clk);
        end
        tick();
        wait_idle(20);
        chk("burst_wc", word_count, 8);

        // Backpressure: only two reads while stalled, then gapless drain
        do_reset();
        en = 1'b0;
        m_ready = 1'b0;
        preload(8, 1);
        en = 1'b1;
        r0 = n_reads;
        repeat (10) tick();
        chk("bp_reads", n_reads - r0, 2);
        @(negedge clk);
        chk("bp_ren", fifo_r_en, 0);
        chk("bp_data", m_data, 8'h01);
        tick();
        m_ready = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            chk("bp_vld", m_valid, 1);
            @(negedge clk);
        end
        tick();
        wait_idle(20);
        chk("bp_wc", word_count, 8);

        // Enable gating: stop after 3 reads, resume with word 4
        do_reset();
        en = 1'b0;
        preload(8, 1);
        en = 1'b1;
        for (int i = 0; i < 20 && n_reads < 3; i++) tick();
        en = 1'b0;
        chk("gate_reads", n_reads, 3);
        repeat (8) tick();
        @(negedge clk);
        chk("gate_wc", word_count, 3);
        chk("gate_idle", idle, 1);
        tick();
        en = 1'b1;
        wait_idle(30);
        chk("gate_wc_all", word_count, 8);

        // Reset mid-burst discards everything
        en = 1'b0;
        preload(8, 1);
        en = 1'b1;
        repeat (4) tick();
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_valid", m_valid, 0);
        chk("midrst_ren", fifo_r_en, 0);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_wc", word_count, 0);
        chk("midrst_idle", idle, 1);
        tick();

        // Counter wrap on the 4-bit instance
        preload(17, 8'h40);
        wait_idle(40);
        chk("wrap4", wc4, 1);
        chk("wrap16", word_count, 17);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 599) == 0) begin
                wr_en = 1'b0;
                do_reset();
            end
            en      = ($urandom_range(0, 3) != 0);
            m_ready = ($urandom_range(0, 2) != 0);
            wr_en   = ($urandom_range(0, 1) != 0);
            wr_data = 8'($urandom);
            tick();
        end
        wr_en = 1'b0;
        en = 1'b1;
        m_ready = 1'b1;
        wait_idle(3000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
